// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared RV32I pipeline constants
package pipe_pkg;

  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  localparam logic [1:0] WBSRC_MEM = 2'b01;

  localparam logic [31:0] NOP_INST = 32'h00000013;

endpackage

// File: rtl/register_unit.sv
// rtl/register_unit.sv - 32x32 register file, x0 hardwired, WB write-through
module register_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic        wr_en,
  input  logic [4:0]  rd,
  input  logic [31:0] wr_data,
  output logic [31:0] rs1_data,
  output logic [31:0] rs2_data
);

  logic [31:0] regs [32];
  logic        wr_ok;

  assign wr_ok = wr_en && (rd != 5'd0);

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) regs[i] <= 32'h0;
    end else if (wr_ok) begin
      regs[rd] <= wr_data;
    end
  end

  // Bypass lets an instruction in ID see the value WB is writing this cycle.
  always_comb begin
    if (rs1 == 5'd0)                rs1_data = 32'h0;
    else if (wr_ok && (rd == rs1))  rs1_data = wr_data;
    else                            rs1_data = regs[rs1];

    if (rs2 == 5'd0)                rs2_data = 32'h0;
    else if (wr_ok && (rd == rs2))  rs2_data = wr_data;
    else                            rs2_data = regs[rs2];
  end

endmodule

// File: rtl/decode_stage.sv
// rtl/decode_stage.sv - RV32I ID stage: IF/ID register, regfile, immediates, load-use hazard
module decode_stage #(
  parameter logic [31:0] NOP_INST = pipe_pkg::NOP_INST,
  parameter logic [31:0] RESET_PC = 32'h00000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] Inst_fe,
  input  logic [31:0] PC_fe,
  input  logic [31:0] PCP4_fe,
  input  logic        Flush,
  input  logic        RUWr_ex,
  input  logic [1:0]  RUDataWrSrc_ex,
  input  logic [4:0]  RD_ex,
  input  logic        RUWr_wb,
  input  logic [4:0]  RD_wb,
  input  logic [31:0] RUDataWr_wb,
  output logic [31:0] PC_de,
  output logic [31:0] PCP4_de,
  output logic [6:0]  opcode_de,
  output logic [2:0]  funct3_de,
  output logic [6:0]  funct7_de,
  output logic [31:0] RUrs1_de,
  output logic [31:0] RUrs2_de,
  output logic [31:0] ImmExt_de,
  output logic [4:0]  RD_de,
  output logic [4:0]  rs1_de,
  output logic [4:0]  rs2_de,
  output logic        Stall,
  output logic        ClrHaz
);

  import pipe_pkg::*;

  logic [31:0] inst_q;
  logic [31:0] pc_q;
  logic [31:0] pcp4_q;
  logic        hz;

  // A flush beats a stall: the stalled instruction is on the wrong path anyway.
  always_ff @(posedge clk) begin
    if (rst || Flush) begin
      inst_q <= NOP_INST;
      pc_q   <= RESET_PC;
      pcp4_q <= RESET_PC + 32'd4;
    end else if (!Stall) begin
      inst_q <= Inst_fe;
      pc_q   <= PC_fe;
      pcp4_q <= PCP4_fe;
    end
  end

  assign PC_de     = pc_q;
  assign PCP4_de   = pcp4_q;
  assign opcode_de = inst_q[6:0];
  assign funct3_de = inst_q[14:12];
  assign funct7_de = inst_q[31:25];
  assign RD_de     = inst_q[11:7];
  assign rs1_de    = inst_q[19:15];
  assign rs2_de    = inst_q[24:20];

  register_unit u_regs (
    .clk      (clk),
    .rst      (rst),
    .rs1      (rs1_de),
    .rs2      (rs2_de),
    .wr_en    (RUWr_wb),
    .rd       (RD_wb),
    .wr_data  (RUDataWr_wb),
    .rs1_data (RUrs1_de),
    .rs2_data (RUrs2_de)
  );

  // rs fields are compared for every format; spurious U/J stalls are harmless.
  assign hz = RUWr_ex && (RUDataWrSrc_ex == WBSRC_MEM) && (RD_ex != 5'd0) &&
              ((RD_ex == rs1_de) || (RD_ex == rs2_de));
  assign Stall  = hz && !Flush;
  assign ClrHaz = hz && !Flush;

  always_comb begin
    ImmExt_de = 32'h0;
    case (opcode_de)
      OP_IMM, OP_LOAD, OP_JALR:
        ImmExt_de = {{20{inst_q[31]}}, inst_q[31:20]};
      OP_STORE:
        ImmExt_de = {{20{inst_q[31]}}, inst_q[31:25], inst_q[11:7]};
      OP_BRANCH:
        ImmExt_de = {{19{inst_q[31]}}, inst_q[31], inst_q[7], inst_q[30:25],
                     inst_q[11:8], 1'b0};
      OP_LUI, OP_AUIPC:
        ImmExt_de = {inst_q[31:12], 12'h000};
      OP_JAL:
        ImmExt_de = {{11{inst_q[31]}}, inst_q[31], inst_q[19:12], inst_q[20],
                     inst_q[30:21], 1'b0};
      default:
        ImmExt_de = 32'h0;
    endcase
  end

endmodule

// File: tb/tb_decode_stage.sv
// tb/tb_decode_stage.sv - directed vector bench for decode_stage
module tb_decode_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] Inst_fe, PC_fe, PCP4_fe;
  logic        Flush, RUWr_ex;
  logic [1:0]  RUDataWrSrc_ex;
  logic [4:0]  RD_ex;
  logic        RUWr_wb;
  logic [4:0]  RD_wb;
  logic [31:0] RUDataWr_wb;
  logic [31:0] PC_de, PCP4_de, RUrs1_de, RUrs2_de, ImmExt_de;
  logic [6:0]  opcode_de, funct7_de;
  logic [2:0]  funct3_de;
  logic [4:0]  RD_de, rs1_de, rs2_de;
  logic        Stall, ClrHaz;

  int n_vec  = 0;
  int n_miss = 0;

  always #5 clk = ~clk;

  decode_stage dut (
    .clk(clk), .rst(rst), .Inst_fe(Inst_fe), .PC_fe(PC_fe), .PCP4_fe(PCP4_fe),
    .Flush(Flush), .RUWr_ex(RUWr_ex), .RUDataWrSrc_ex(RUDataWrSrc_ex), .RD_ex(RD_ex),
    .RUWr_wb(RUWr_wb), .RD_wb(RD_wb), .RUDataWr_wb(RUDataWr_wb),
    .PC_de(PC_de), .PCP4_de(PCP4_de), .opcode_de(opcode_de), .funct3_de(funct3_de),
    .funct7_de(funct7_de), .RUrs1_de(RUrs1_de), .RUrs2_de(RUrs2_de),
    .ImmExt_de(ImmExt_de), .RD_de(RD_de), .rs1_de(rs1_de), .rs2_de(rs2_de),
    .Stall(Stall), .ClrHaz(ClrHaz)
  );

  typedef struct {
    logic [31:0] inst;
    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic [31:0] imm;
  } vec_t;

  vec_t vecs [10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    vecs[0] = '{32'hFFF00093, 7'h13, 5'd1,  32'hFFFFFFFF};  // addi x1,x0,-1
    vecs[1] = '{32'hFE112E23, 7'h23, 5'd28, 32'hFFFFFFFC};  // sw x1,-4(x2)
    vecs[2] = '{32'hFE000EE3, 7'h63, 5'd29, 32'hFFFFFFFC};  // beq x0,x0,-4
    vecs[3] = '{32'h12345037, 7'h37, 5'd0,  32'h12345000};  // lui x0,0x12345
    vecs[4] = '{32'h008000EF, 7'h6F, 5'd1,  32'h00000008};  // jal x1,8
    vecs[5] = '{32'h00500093, 7'h13, 5'd1,  32'h00000005};  // addi x1,x0,5
    vecs[6] = '{32'h0080A103, 7'h03, 5'd2,  32'h00000008};  // lw x2,8(x1)
    vecs[7] = '{32'h00001117, 7'h17, 5'd2,  32'h00001000};  // auipc x2,1
    vecs[8] = '{32'h000080E7, 7'h67, 5'd1,  32'h00000000};  // jalr x1,0(x1)
    vecs[9] = '{32'h00528333, 7'h33, 5'd6,  32'h00000000};  // add x6,x5,x5

    rst = 1'b1; Inst_fe = 32'h00500093; PC_fe = 32'h100; PCP4_fe = 32'h104;
    Flush = 1'b0; RUWr_ex = 1'b0; RUDataWrSrc_ex = 2'b00; RD_ex = 5'd0;
    RUWr_wb = 1'b0; RD_wb = 5'd0; RUDataWr_wb = 32'h0;
    step();
    check("rst_opcode", {25'h0, opcode_de}, 32'h13);
    check("rst_rd", {27'h0, RD_de}, 32'h0);
    check("rst_imm", ImmExt_de, 32'h0);
    check("rst_stall", {31'h0, Stall}, 32'h0);
    check("rst_clrhaz", {31'h0, ClrHaz}, 32'h0);
    check("rst_pc", PC_de, 32'h0);
    check("rst_pcp4", PCP4_de, 32'h4);
    rst = 1'b0;

    for (int k = 1; k < 32; k++) begin
      logic [4:0] r;
      r = 5'(k);
      Inst_fe = {7'h0, r, r, 3'b000, 5'd0, 7'h33};
      step();
      check("rst_reg_rs1", RUrs1_de, 32'h0);
      check("rst_reg_rs2", RUrs2_de, 32'h0);
    end

    for (int i = 0; i < 10; i++) begin
      Inst_fe = vecs[i].inst;
      step();
      check("vec_opcode", {25'h0, opcode_de}, {25'h0, vecs[i].opcode});
      check("vec_rd", {27'h0, RD_de}, {27'h0, vecs[i].rd});
      check("vec_imm", ImmExt_de, vecs[i].imm);
    end
    check("add_rs1", {27'h0, rs1_de}, 32'd5);
    check("add_rs2", {27'h0, rs2_de}, 32'd5);

    // write-through: IF/ID holds add x6,x5,x5
    RUWr_wb = 1'b1; RD_wb = 5'd5; RUDataWr_wb = 32'hDEADBEEF;
    #1;
    check("wt_rs1", RUrs1_de, 32'hDEADBEEF);
    check("wt_rs2", RUrs2_de, 32'hDEADBEEF);
    step();
    RUWr_wb = 1'b0;
    #1;
    check("wt_stored_rs1", RUrs1_de, 32'hDEADBEEF);
    check("wt_stored_rs2", RUrs2_de, 32'hDEADBEEF);

    Inst_fe = 32'h00000033;
    RUWr_wb = 1'b1; RD_wb = 5'd0; RUDataWr_wb = 32'h12345678;
    step();
    check("x0_bypass", RUrs1_de, 32'h0);
    RUWr_wb = 1'b0;
    step();
    check("x0_stored", RUrs1_de, 32'h0);

    // load-use: add x6,x5,x1 behind lw x5
    Inst_fe = 32'h00128333; PC_fe = 32'h3C; PCP4_fe = 32'h40;
    step();
    RUWr_ex = 1'b1; RUDataWrSrc_ex = 2'b01; RD_ex = 5'd5;
    Inst_fe = 32'h00A00513; PC_fe = 32'h40; PCP4_fe = 32'h44;
    #1;
    check("lu_stall", {31'h0, Stall}, 32'h1);
    check("lu_clrhaz", {31'h0, ClrHaz}, 32'h1);
    step();
    RD_ex = 5'd0;
    check("lu_held_opcode", {25'h0, opcode_de}, 32'h33);
    check("lu_held_rd", {27'h0, RD_de}, 32'd6);
    check("lu_held_pc", PC_de, 32'h3C);
    #1;
    check("lu_released", {31'h0, Stall}, 32'h0);
    step();
    check("lu_adv_rd", {27'h0, RD_de}, 32'd10);
    check("lu_adv_pc", PC_de, 32'h40);

    // addi x10,x0,10: rs2 field equals 10
    RD_ex = 5'd10; RUDataWrSrc_ex = 2'b00;
    #1;
    check("nohz_alu_src", {31'h0, Stall}, 32'h0);
    RD_ex = 5'd0; RUDataWrSrc_ex = 2'b01;
    #1;
    check("nohz_rd0", {31'h0, Stall}, 32'h0);
    RD_ex = 5'd10;
    #1;
    check("hz_rs2_field", {31'h0, Stall}, 32'h1);
    Flush = 1'b1;
    #1;
    check("flush_stall", {31'h0, Stall}, 32'h0);
    check("flush_clrhaz", {31'h0, ClrHaz}, 32'h0);
    step();
    Flush = 1'b0; RUWr_ex = 1'b0;
    check("flush_opcode", {25'h0, opcode_de}, 32'h13);
    check("flush_pc", PC_de, 32'h0);
    check("flush_pcp4", PCP4_de, 32'h4);

    for (int i = 0; i < 3; i++) begin
      Inst_fe = {12'd0, 5'd0, 3'b000, 5'(i + 1), 7'h13};
      PC_fe = 32'(4 * i); PCP4_fe = 32'(4 * i + 4);
      step();
      check("flow_pc", PC_de, 32'(4 * i));
      check("flow_pcp4", PCP4_de, 32'(4 * i + 4));
      check("flow_rd", {27'h0, RD_de}, 32'(i + 1));
    end

    // reset beats a simultaneous WB write and clears earlier contents
    Inst_fe = 32'h00728333;
    rst = 1'b1; RUWr_wb = 1'b1; RD_wb = 5'd7; RUDataWr_wb = 32'hCAFEF00D;
    step();
    rst = 1'b0; RUWr_wb = 1'b0;
    step();
    check("rst_x5_cleared", RUrs1_de, 32'h0);
    check("rst_x7_blocked", RUrs2_de, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
